// File: rtl/fact_arbiter.sv
// fact_arbiter
// Shares one factorial accelerator between two requesters (port 0: CPU
// memory-mapped path, port 1: GPI-driven path). A granted request is acked,
// its operand latched, the accelerator started with a go pulse and the
// result delivered to the owning port with a one-cycle done pulse.
// Operands above MAX_N are rejected without starting the unit, and a unit
// that never completes is abandoned after TIMEOUT cycles with an error.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req0/n0           requester 0 request (held until ack0) and operand
//   ack0              one-cycle pulse: request 0 accepted, n0 latched
//   done0             one-cycle pulse: res0/err0 updated
//   res0/err0         requester 0 result and error, held until next delivery
//   req1..err1        same as port 0, for requester 1
//   fu_go/fu_n        start pulse and operand to the accelerator
//   fu_done/fu_result accelerator completion level and product
//   busy              high whenever the arbiter is not idle
module fact_arbiter #(
    parameter int MAX_N   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [3:0]  n0,
    output logic        ack0,
    output logic        done0,
    output logic [31:0] res0,
    output logic        err0,
    input  logic        req1,
    input  logic [3:0]  n1,
    output logic        ack1,
    output logic        done1,
    output logic [31:0] res1,
    output logic        err1,
    output logic        fu_go,
    output logic [3:0]  fu_n,
    input  logic        fu_done,
    input  logic [31:0] fu_result,
    output logic        busy
);

    localparam int         CW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0] MAX_N_L   = 4'(MAX_N);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        DELIVER
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic [3:0]    n_lat;
    logic [31:0]   cap_res;
    logic          cap_err;
    logic [CW-1:0] cnt;

    logic       grant1;
    logic [3:0] sel_n;
    logic       timeout_hit;

    // On a tie the port that was not served last wins; a lone request wins.
    assign grant1 = req1 && (!req0 || !last_grant);
    assign sel_n  = grant1 ? n1 : n0;

    // Abandon the job on the cycle the counter would step onto TIMEOUT-1,
    // which places the done pulse exactly TIMEOUT cycles after fu_go.
    assign timeout_hit = (cnt + CW'(1)) == TO_LAST;

    assign busy = (state != IDLE);

    // NOTE: all state and outputs here are registers, so every assignment in
    // this block is non-blocking; pulses are cleared by default each cycle
    // and set only in the branch that raises them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            n_lat      <= '0;
            cap_res    <= '0;
            cap_err    <= 1'b0;
            cnt        <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            res0       <= '0;
            res1       <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            fu_go      <= 1'b0;
            fu_n       <= '0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            fu_go <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        ack0       <= !grant1;
                        ack1       <= grant1;
                        n_lat      <= sel_n;
                        if (sel_n > MAX_N_L) begin
                            cap_res <= '0;
                            cap_err <= 1'b1;
                            state   <= DELIVER;
                        end else begin
                            state   <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    fu_go <= 1'b1;
                    fu_n  <= n_lat;
                    cnt   <= '0;
                    state <= WAIT_LO;
                end

                // A done level left over from the previous job must drop
                // before a completion can be trusted.
                WAIT_LO: begin
                    cnt <= cnt + CW'(1);
                    if (timeout_hit) begin
                        cap_res <= '0;
                        cap_err <= 1'b1;
                        state   <= DELIVER;
                    end else if (!fu_done) begin
                        state <= WAIT_HI;
                    end
                end

                // Completion takes precedence over a coincident timeout.
                WAIT_HI: begin
                    cnt <= cnt + CW'(1);
                    if (fu_done) begin
                        cap_res <= fu_result;
                        cap_err <= 1'b0;
                        state   <= DELIVER;
                    end else if (timeout_hit) begin
                        cap_res <= '0;
                        cap_err <= 1'b1;
                        state   <= DELIVER;
                    end
                end

                DELIVER: begin
                    if (owner) begin
                        res1  <= cap_res;
                        err1  <= cap_err;
                        done1 <= 1'b1;
                    end else begin
                        res0  <= cap_res;
                        err0  <= cap_err;
                        done0 <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_arbiter.sv
// Testbench for fact_arbiter. A transaction-level model schedules, for every
// granted request, the cycles of ack, fu_go and done from the latency rules
// and the expected result from a plain factorial; one process compares every
// DUT output against that schedule on every cycle. A responder models the
// accelerator with a programmable latency and a sticky done level.
module tb_fact_arbiter;

    localparam int MAX_N   = 12;
    localparam int TIMEOUT = 64;
    localparam int NC      = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  n0 = '0, n1 = '0;
    logic        ack0, ack1, done0, done1, err0, err1, fu_go, busy;
    logic [31:0] res0, res1;
    logic [3:0]  fu_n;
    logic        fu_done = 1'b0;
    logic [31:0] fu_result = '0;

    int unit_lat = 3;   // 0 = unit never completes

    int n_checks = 0;
    int n_err    = 0;

    fact_arbiter #(.MAX_N(MAX_N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .n0(n0), .ack0(ack0), .done0(done0), .res0(res0), .err0(err0),
        .req1(req1), .n1(n1), .ack1(ack1), .done1(done1), .res1(res1), .err1(err1),
        .fu_go(fu_go), .fu_n(fu_n), .fu_done(fu_done), .fu_result(fu_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] p = 32'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
        return p;
    endfunction

    // Expected-event schedule, indexed by cycle number.
    bit [1:0]    e_ack  [NC];
    bit [1:0]    e_done [NC];
    logic [31:0] e_val  [NC];
    bit          e_err  [NC];
    bit          e_go   [NC];
    logic [3:0]  e_gn   [NC];
    bit          e_busy [NC];

    int cyc    = 0;
    int m_free = 0;
    int m_go   = 0;
    bit m_last = 1'b1;
    logic [31:0] x_res0 = '0, x_res1 = '0;
    logic        x_err0 = 1'b0, x_err1 = 1'b0;
    logic [3:0]  x_fun = '0;

    int obs_go_cyc = -1, obs_done0_cyc = -1, obs_done1_cyc = -1, go_count = 0;

    bit have_go = 1'b0;
    int go_c = 0;
    logic [3:0] go_n = '0;

    // Compare, respond, then advance the model, once per cycle.
    always @(negedge clk) begin
        automatic int c = cyc;
        automatic bit p;
        automatic logic [3:0] nn;
        automatic int d;

        if (e_done[c][0]) begin x_res0 = e_val[c]; x_err0 = e_err[c]; end
        if (e_done[c][1]) begin x_res1 = e_val[c]; x_err1 = e_err[c]; end
        if (e_go[c]) x_fun = e_gn[c];

        check("ack0",  32'(ack0),  32'(e_ack[c][0]));
        check("ack1",  32'(ack1),  32'(e_ack[c][1]));
        check("done0", 32'(done0), 32'(e_done[c][0]));
        check("done1", 32'(done1), 32'(e_done[c][1]));
        check("fu_go", 32'(fu_go), 32'(e_go[c]));
        check("busy",  32'(busy),  32'(e_busy[c]));
        check("fu_n",  32'(fu_n),  32'(x_fun));
        check("res0",  res0,       x_res0);
        check("err0",  32'(err0),  32'(x_err0));
        check("res1",  res1,       x_res1);
        check("err1",  32'(err1),  32'(x_err1));

        if (fu_go === 1'b1) begin obs_go_cyc = c; go_count++; end
        if (done0 === 1'b1) obs_done0_cyc = c;
        if (done1 === 1'b1) obs_done1_cyc = c;

        // Accelerator: done level stays as-is in the go cycle, drops after,
        // rises unit_lat cycles after go and then stays high.
        if (fu_go === 1'b1) begin
            have_go = 1'b1;
            go_c    = c;
            go_n    = fu_n;
        end else if (have_go && c > go_c) begin
            if (unit_lat != 0 && c - go_c >= unit_lat) begin
                fu_done   = 1'b1;
                fu_result = fact(go_n);
            end else begin
                fu_done   = 1'b0;
                fu_result = 32'hDEAD_BEEF;
            end
        end

        if (rst) begin
            for (int j = c + 1; j < NC; j++) begin
                e_ack[j] = '0; e_done[j] = '0; e_go[j] = 1'b0; e_busy[j] = 1'b0;
            end
            x_res0 = '0; x_res1 = '0; x_err0 = 1'b0; x_err1 = 1'b0; x_fun = '0;
            m_last = 1'b1;
            m_free = c + 1;
        end else if (c >= m_free && (req0 || req1) && c + 2 * TIMEOUT < NC) begin
            p  = (req0 && req1) ? !m_last : req1;
            nn = p ? n1 : n0;
            m_last = p;
            e_ack[c + 1][p] = 1'b1;
            if (int'(nn) > MAX_N) begin
                d = c + 2;
                e_val[d] = '0; e_err[d] = 1'b1;
            end else begin
                m_go = c + 2;
                e_go[m_go] = 1'b1;
                e_gn[m_go] = nn;
                if (unit_lat == 0) begin
                    d = m_go + TIMEOUT;
                    e_val[d] = '0; e_err[d] = 1'b1;
                end else begin
                    d = c + unit_lat + 4;
                    e_val[d] = fact(nn); e_err[d] = 1'b0;
                end
            end
            e_done[d][p] = 1'b1;
            for (int j = c + 1; j < d; j++) e_busy[j] = 1'b1;
            m_free = d;
        end

        cyc = c + 1;
    end

    // Advance one cycle; a requester drops req the cycle after its ack.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc > 0 && e_ack[cyc - 1][0]) req0 = 1'b0;
        if (cyc > 0 && e_ack[cyc - 1][1]) req1 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (!req0 && !req1 && cyc > m_free) ok = 1'b1;
            else tick();
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int t_req, g_before;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request on port 0, 3-cycle unit.
        unit_lat = 3;
        req0 = 1'b1; n0 = 4'd5;
        tick();
        wait_idle("t1");
        check("t1_res0", res0, 32'd120);
        check("t1_err0", 32'(err0), 32'd0);
        check("t1_res1", res1, 32'd0);

        // Simultaneous pair after reset: port 0 wins the first tie.
        pulse_rst();
        req0 = 1'b1; n0 = 4'd5; req1 = 1'b1; n1 = 4'd6;
        tick();
        wait_idle("t2a");
        check("t2_res0", res0, 32'd120);
        check("t2_res1", res1, 32'd720);
        check("t2_order", 32'(obs_done0_cyc < obs_done1_cyc), 32'd1);
        // Port 0 with n=0 so the next tie goes to port 1.
        req0 = 1'b1; n0 = 4'd0;
        tick();
        wait_idle("t2b");
        check("t2_res0_n0", res0, 32'd1);
        req0 = 1'b1; n0 = 4'd2; req1 = 1'b1; n1 = 4'd3;
        tick();
        wait_idle("t2c");
        check("t2_res0b", res0, 32'd2);
        check("t2_res1b", res1, 32'd6);
        check("t2_order_b", 32'(obs_done1_cyc < obs_done0_cyc), 32'd1);

        // Largest accepted operand, then a rejected one.
        req1 = 1'b1; n1 = 4'd12;
        tick();
        wait_idle("t3a");
        check("t3_res1", res1, 32'd479001600);
        check("t3_err1", 32'(err1), 32'd0);
        g_before = go_count;
        req1 = 1'b1; n1 = 4'd13; t_req = cyc;
        tick();
        n1 = 4'd1;
        wait_idle("t3b");
        check("t3_rej_lat", 32'(obs_done1_cyc - t_req), 32'd2);
        check("t3_rej_err", 32'(err1), 32'd1);
        check("t3_rej_res", res1, 32'd0);
        check("t3_rej_nogo", 32'(go_count - g_before), 32'd0);

        // Stale done level from the previous job, new done 2 cycles after go.
        unit_lat = 2;
        req0 = 1'b1; n0 = 4'd7;
        tick();
        n0 = 4'd9;
        wait_idle("t4");
        check("t4_res0", res0, 32'd5040);
        check("t4_err0", 32'(err0), 32'd0);

        // Hung unit: timeout.
        unit_lat = 0;
        req0 = 1'b1; n0 = 4'd4;
        tick();
        wait_idle("t5");
        check("t5_to_lat", 32'(obs_done0_cyc - obs_go_cyc), 32'd64);
        check("t5_err0", 32'(err0), 32'd1);
        check("t5_res0", res0, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);

        // Reset during WAIT_HI abandons the job.
        unit_lat = 10;
        req0 = 1'b1; n0 = 4'd4;
        tick();
        for (int i = 0; i < 50 && cyc != m_go + 4; i++) tick();
        pulse_rst();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_err0", 32'(err0), 32'd0);
        check("t6_res0", res0, 32'd0);
        repeat (12) tick();
        unit_lat = 3;
        req0 = 1'b1; n0 = 4'd3;
        tick();
        wait_idle("t6");
        check("t6_res0b", res0, 32'd6);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fact_arbiter.md
Name: fact_arbiter

Overview:
- Shares one factorial accelerator between two requesters: port 0 is the CPU memory-mapped path and port 1 is the GPI-driven path.
- Sequences the accelerator with a go/done handshake.
- Rejects operands whose factorial overflows 32 bits.
- Guards against a hung unit with a timeout.
- Sits in mips_top between the bus decode and the factorial accelerator.

Parameters:
- MAX_N, 12, largest n accepted (13! overflows 32 bits).
- TIMEOUT, 64, cycles allowed from go to done before an error is flagged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 request; held until ack0
- n0  in  4  requester 0 operand
- ack0  out  1  one-cycle pulse: request 0 accepted, n0 latched
- done0  out  1  one-cycle pulse: res0/err0 valid
- res0  out  32  requester 0 result, held until next delivery to port 0
- err0  out  1  requester 0 error, held with res0
- req1, n1, ack1, done1, res1, err1: same as port 0, for requester 1
- fu_go  out  1  one-cycle start pulse to accelerator
- fu_n  out  4  operand to accelerator, stable from ISSUE until next ISSUE
- fu_done  in  1  accelerator done, level; may be stale-high at go
- fu_result  in  32  accelerator product, valid while fu_done=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - ack*, done*, res*, err*, fu_go and fu_n go to 0; timeout counter goes to 0; last_grant goes to 1, so port 0 wins the first tie.
  - Reset mid-operation abandons the job without delivering. A still-running unit is tolerated because of WAIT_LO.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant (round-robin).
  - On grant, in the next cycle: ack of the granted port=1 for one cycle, n latched, owner register set, last_grant=owner.
  - If latched n>MAX_N, go to DELIVER with err=1 and result 0; the unit is not started. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - fu_go=1, fu_n=latched n.
  - Timeout counter cleared; go to WAIT_LO.
- WAIT_LO: stay until fu_done=0, then go to WAIT_HI. This discards a stale done level from the previous job.
- WAIT_HI: on fu_done=1, capture fu_result, set err=0, go to DELIVER.
- Timeout:
  - The counter increments every cycle in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT-1 without completion, go to DELIVER with err=1 and result 0.
  - If timeout and fu_done=1 coincide in WAIT_HI, completion wins.
- DELIVER (1 cycle):
  - res/err of the owner are registered from the captured values; the owner's done=1.
  - The other port's outputs are unchanged. Go to IDLE.
- Request handling:
  - Requests arriving while busy wait; req must stay high until ack.
  - A req still high in IDLE after DELIVER is treated as a new request.
  - A requester drops req the cycle after its ack.
- Latency, n<=MAX_N, unit done k cycles after go: ack at T+1, fu_go at T+2, done at T+k+4 (T = first IDLE cycle with req high).
  - Minimum turnaround: 5 cycles from req to done.
- Rejected n: ack at T+1, done at T+2.
- n=0 and n=1 are passed to the unit unchanged; no special case.
- The n0/n1 value is sampled only in the grant cycle; later changes are ignored.

Test Plan:
- req0=1, n0=5, unit model with 3-cycle latency -> ack0 pulse, then fu_go with fu_n=5, then done0 with res0=120, err0=0; port 1 outputs stay 0.
- req0 and req1 asserted in the same cycle, n0=5, n1=6 -> port 0 served first (res0=120), then port 1 (res1=720); a second simultaneous pair is served port 1 first.
- req1=1, n1=12 -> res1=479001600, err1=0. Then n1=13 -> done1 two cycles after req, err1=1, res1=0, fu_go never asserted.
- Unit model holds fu_done=1 from the prior job and asserts it again 2 cycles after go -> controller waits for fu_done low and returns the new product, not the stale one.
- Unit model never asserts fu_done, TIMEOUT=64 -> done0 with err0=1, res0=0, exactly 64 cycles after fu_go; busy low afterwards.
- rst=1 for one cycle during WAIT_HI -> next cycle: busy=0 and all outputs 0. No done pulse; next request (n0=3) returns res0=6.
